// File: rtl/uart_ctrl_pkg.sv
// Shared types, widths and the round-robin pick helper for the UART control slice.
package uart_ctrl_pkg;

  localparam int unsigned DIVSR_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PICK_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CFG
  } arb_state_e;

  // One-hot winner: first set bit of req searching upward from last+1, wrapping at n.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [PICK_W-1:0] req,
                                                input int unsigned       n,
                                                input int unsigned       last);
    logic [PICK_W-1:0] oh;
    logic [2:0]        sel;
    oh = '0;
    for (int unsigned k = 1; k <= PICK_W; k++) begin
      if (k <= n) begin
        sel = 3'((last + k) % n);
        if (oh == '0 && req[sel]) oh[sel] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus its index from a request vector.
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [PICK_W-1:0] req_ext;
  logic [PICK_W-1:0] pick_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick_ext       = rr_pick(req_ext, N, 32'(last));
    onehot         = pick_ext[N-1:0];
    any            = |pick_ext;
    idx            = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_ext[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of the UART TX path, plus divisor ownership
// with updates deferred until no transmit bytes are in flight.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned        NREQ      = 4,
  parameter int unsigned        MAX_PKT   = 16,
  parameter int unsigned        TXQ_DEPTH = 16,
  parameter logic [DIVSR_W-1:0] DIVSR_RST = 10'd650
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          grant,
  input  logic                     tx_full,
  input  logic                     tx_done,
  output logic                     wr_uart,
  output logic [DATA_W-1:0]        w_data,
  input  logic                     cfg_wr,
  input  logic [DIVSR_W-1:0]       cfg_divsr,
  output logic                     cfg_ack,
  output logic [DIVSR_W-1:0]       divsr,
  output logic                     busy
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned FW = $clog2(TXQ_DEPTH + 2);

  arb_state_e         state, state_nx;
  logic [GW-1:0]      last_grant, grant_idx, pick_idx;
  logic [NREQ-1:0]    grant_oh, pick_oh;
  logic               pick_any;
  logic [7:0]         byte_cnt;
  logic               cfg_pending;
  logic [DIVSR_W-1:0] cfg_val;
  logic [FW-1:0]      inflight;
  logic               xfer, pkt_end, tx_ack;

  uart_rr_pick #(.N(NREQ), .IW(GW)) u_pick (
    .req    (req_valid),
    .last   (last_grant),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant     = '0;
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    cfg_ack   = 1'b0;
    xfer      = 1'b0;
    pkt_end   = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending divisor blocks new grants until the UART has drained.
        if (cfg_pending) begin
          if (inflight == '0) state_nx = CFG;
        end else if (pick_any) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        grant                = grant_oh;
        req_ready[grant_idx] = !tx_full;
        w_data               = req_data[grant_idx*DATA_W +: DATA_W];
        xfer                 = req_valid[grant_idx] && !tx_full;
        wr_uart              = xfer;
        pkt_end              = xfer && (req_last[grant_idx] || byte_cnt == 8'(MAX_PKT - 1));
        if (pkt_end) state_nx = IDLE;
      end
      CFG: begin
        cfg_ack  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx_ack = tx_done && (inflight != '0);
  assign busy   = (state != IDLE) || (inflight != '0);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      grant_oh    <= '0;
      grant_idx   <= '0;
      last_grant  <= GW'(NREQ - 1);
      byte_cnt    <= '0;
      cfg_pending <= 1'b0;
      cfg_val     <= '0;
      divsr       <= DIVSR_RST;
      inflight    <= '0;
    end else begin
      if (state == IDLE && !cfg_pending && pick_any) begin
        grant_oh  <= pick_oh;
        grant_idx <= pick_idx;
        byte_cnt  <= '0;
      end
      if (xfer)    byte_cnt   <= byte_cnt + 8'd1;
      if (pkt_end) last_grant <= grant_idx;

      // A write landing in the CFG cycle stays pending and triggers another CFG.
      if (cfg_wr) begin
        cfg_val     <= cfg_divsr;
        cfg_pending <= 1'b1;
      end else if (state == CFG) begin
        cfg_pending <= 1'b0;
      end
      if (state == CFG) divsr <= cfg_val;

      unique case ({wr_uart, tx_ack})
        2'b10:   if (inflight != '1) inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued agents, a UART stand-in and a packet-level reference.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned MAXP = 4;
  localparam int unsigned TXQ  = 16;
  localparam logic [9:0]  DRST = 10'd650;

  logic              CLK = 1'b0;
  logic              Reset_n;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [NREQ*8-1:0] req_data;
  logic              tx_full, tx_done, wr_uart, cfg_wr, cfg_ack, busy;
  logic [7:0]        w_data;
  logic [9:0]        cfg_divsr, divsr;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_PKT(MAXP), .TXQ_DEPTH(TXQ), .DIVSR_RST(DRST)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_full(tx_full),
    .tx_done(tx_done), .wr_uart(wr_uart), .w_data(w_data), .cfg_wr(cfg_wr),
    .cfg_divsr(cfg_divsr), .cfg_ack(cfg_ack), .divsr(divsr), .busy(busy)
  );

  int unsigned n_assert = 0, n_fail = 0;
  logic [8:0]  abuf [NREQ][64];
  int unsigned ahead [NREQ];
  int unsigned atail [NREQ];
  logic [10:0] exp_q [$];
  int unsigned m_last = NREQ - 1;
  int unsigned uc = 0, ack_cnt = 0;
  bit          auto_uart = 0, full_rand = 0, bubble_en = 0, force_full = 0, td_req = 0, cfg_go = 0;
  logic [9:0]  cfg_val_tb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: bound expired or event missing", name);
  endtask

  task automatic clear_agents();
    for (int i = 0; i < NREQ; i++) begin ahead[i] = 0; atail[i] = 0; end
  endtask

  task automatic push_byte(input int unsigned r, input logic [7:0] d, input bit last);
    abuf[r][atail[r]] = {last, d};
    atail[r]++;
  endtask

  function automatic bit agents_empty();
    for (int i = 0; i < NREQ; i++) if (ahead[i] != atail[i]) return 0;
    return 1;
  endfunction

  // Reference: every loaded requester keeps asking; each grant carries bytes up to
  // end-of-packet or MAXP bytes, and the next owner is searched from the previous one + 1.
  function automatic void model();
    int unsigned pos [NREQ];
    int unsigned i, n;
    bit          found;
    logic [8:0]  b;
    for (int k = 0; k < NREQ; k++) pos[k] = ahead[k];
    forever begin
      found = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (pos[i] < atail[i]) begin found = 1; break; end
      end
      if (!found) return;
      n = 0;
      do begin
        b = abuf[i][pos[i]];
        pos[i]++;
        n++;
        exp_q.push_back({3'(i), b[7:0]});
      end while (!b[8] && n < MAXP && pos[i] < atail[i]);
      m_last = i;
    end
  endfunction

  task automatic cycle();
    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) begin
      if (ahead[i] < atail[i]) begin
        req_valid[i]       = !(grant[i] && bubble_en && $urandom_range(0, 3) == 0);
        req_data[8*i +: 8] = abuf[i][ahead[i]][7:0];
        req_last[i]        = abuf[i][ahead[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = '0;
        req_last[i]        = 1'b0;
      end
    end
    tx_full   = force_full || (uc >= TXQ) || (full_rand && $urandom_range(0, 3) == 0);
    tx_done   = td_req || (auto_uart && uc > 0 && $urandom_range(0, 2) == 0);
    cfg_wr    = cfg_go;
    cfg_divsr = cfg_val_tb;
    #4;
    for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) ahead[i]++;
    if (tx_done && uc > 0) uc--;
    if (wr_uart) uc++;
    if (cfg_ack) ack_cnt++;
    td_req = 0;
    cfg_go = 0;
  endtask

  task automatic drain(input int unsigned limit, input string name);
    int unsigned k = 0;
    while (!(agents_empty() && exp_q.size() == 0 && (!auto_uart || uc == 0)) && k < limit) begin
      cycle();
      k++;
    end
    if (k >= limit) begin
      fail_now(name);
      clear_agents();
      exp_q.delete();
    end
  endtask

  // Monitor: every accepted UART write must be the next byte the reference predicted.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge CLK);
      #4;
      if (Reset_n === 1'b1) begin
        check("ready_only_owner", 32'(req_ready & ~grant), 0);
        if (wr_uart) begin
          check("wr_while_full", 32'(tx_full), 0);
          if (exp_q.size() == 0) fail_now("unexpected_byte");
          else begin
            e = exp_q.pop_front();
            check("w_data", 32'(w_data), 32'(e[7:0]));
            check("grant_at_wr", 32'(grant), 32'(1) << e[10:8]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first, lastc, cnt;
    bit          seen;
    Reset_n = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    tx_full = 0; tx_done = 0; cfg_wr = 0; cfg_divsr = '0;
    clear_agents();
    #1 Reset_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr", 32'(wr_uart), 0);
    check("rst_wdata", 32'(w_data), 0);
    check("rst_divsr", 32'(divsr), 32'(DRST));
    check("rst_ack", 32'(cfg_ack), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;

    // Round robin from reset: one byte each, then req0/req2 alternating.
    auto_uart = 1;
    for (int r = 0; r < NREQ; r++) push_byte(r, 8'(8'h10 * (r + 1)), 1);
    model();
    drain(300, "drain_rr");
    clear_agents();
    for (int p = 0; p < 3; p++) begin push_byte(0, 8'(8'h50 + p), 1); push_byte(2, 8'(8'h60 + p), 1); end
    model();
    drain(300, "drain_alt");

    // Backpressure: tx_full for 5 cycles after the first byte.
    auto_uart = 0;
    clear_agents();
    push_byte(1, 8'hB1, 0); push_byte(1, 8'hB2, 0); push_byte(1, 8'hB3, 1);
    model();
    cnt = 0;
    while (ahead[1] == 0 && cnt < 20) begin cycle(); cnt++; end
    if (ahead[1] == 0) fail_now("bp_first_byte");
    force_full = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_wr", 32'(wr_uart), 0);
      check("bp_ready", 32'(req_ready[1]), 0);
      check("bp_held", ahead[1], 1);
    end
    force_full = 0;
    cycle();
    check("bp_resume_wr", 32'(wr_uart), 1);
    check("bp_resume_ptr", ahead[1], 2);
    auto_uart = 1;
    drain(300, "drain_bp");

    // Single packet, UART held so in-flight bytes stay visible through busy.
    auto_uart = 0;
    repeat (3) cycle();
    clear_agents();
    push_byte(0, 8'hA1, 0); push_byte(0, 8'hA2, 0); push_byte(0, 8'hA3, 1);
    model();
    cnt = 0; first = 0; lastc = 0;
    for (int unsigned c = 0; c < 10; c++) begin
      cycle();
      if (wr_uart) begin
        if (cnt == 0) first = c;
        lastc = c;
        cnt++;
      end
    end
    check("single_wr_count", cnt, 3);
    check("single_wr_span", lastc - first, 2);
    check("single_grant_after", 32'(grant), 0);
    check("single_busy_inflight", 32'(busy), 1);
    for (int p = 0; p < 4; p++) begin
      td_req = 1;
      cycle();
      cycle();
      check("inflight_drain_busy", 32'(busy), 32'(uc != 0));
    end

    // Forced release at MAXP: req1 6 bytes, req2 one byte in between.
    clear_agents();
    for (int b = 0; b < 6; b++) push_byte(1, 8'(8'hC0 + b), b == 5);
    push_byte(2, 8'h77, 1);
    model();
    auto_uart = 1;
    drain(400, "drain_maxpkt");

    // Randomised batches with bubbles, random backpressure and random UART drain.
    full_rand = 1; bubble_en = 1;
    for (int bt = 0; bt < 6; bt++) begin
      clear_agents();
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) == 1 || (r == 0 && bt == 0)) begin
          for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
            int unsigned len;
            len = $urandom_range(1, 6);
            for (int unsigned b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
          end
        end
      end
      model();
      drain(3000, "drain_random");
      repeat (2) cycle();
      check("random_idle_busy", 32'(busy), 0);
    end
    full_rand = 0; bubble_en = 0;

    // Divisor update deferred behind two in-flight bytes; second write wins.
    auto_uart = 0;
    check("divsr_before_cfg", 32'(divsr), 32'(DRST));
    clear_agents();
    push_byte(0, 8'h55, 0); push_byte(0, 8'h66, 1);
    model();
    drain(100, "drain_cfg_pre");
    repeat (2) cycle();
    check("cfg_inflight_busy", 32'(busy), 1);
    cfg_go = 1; cfg_val_tb = 10'h145;
    cycle();
    push_byte(3, 8'h99, 1);
    model();
    ack_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin cfg_go = 1; cfg_val_tb = 10'h0A2; end
      cycle();
      check("cfg_hold_grant", 32'(grant), 0);
    end
    check("cfg_no_early_ack", ack_cnt, 0);
    td_req = 1; cycle();
    td_req = 1; cycle();
    cnt = 0; seen = 0;
    while (ack_cnt == 0 && cnt < 10) begin
      cycle();
      if (ack_cnt == 0) check("cfg_wait_no_wr", 32'(wr_uart), 0);
      cnt++;
    end
    if (ack_cnt == 0) fail_now("cfg_ack_timeout");
    cycle();
    check("cfg_divsr_applied", 32'(divsr), 32'h0A2);
    drain(50, "drain_cfg_post");
    repeat (3) cycle();
    check("cfg_single_ack", ack_cnt, 1);

    // Asynchronous reset during byte 2 of 4.
    clear_agents();
    exp_q.delete();
    for (int b = 0; b < 4; b++) push_byte(2, 8'(8'hD0 + b), b == 3);
    model();
    cnt = 0;
    while (ahead[2] == 0 && cnt < 20) begin cycle(); cnt++; end
    if (ahead[2] == 0) fail_now("rst_mid_first_byte");
    @(negedge CLK);
    req_valid[2] = 1'b1; req_data[23:16] = abuf[2][1][7:0]; req_last[2] = 1'b0;
    tx_full = 0; tx_done = 0;
    #2 Reset_n = 1'b0;
    #1;
    check("rstmid_wr", 32'(wr_uart), 0);
    check("rstmid_grant", 32'(grant), 0);
    check("rstmid_divsr", 32'(divsr), 32'(DRST));
    check("rstmid_busy", 32'(busy), 0);
    clear_agents();
    exp_q.delete();
    uc = 0; m_last = NREQ - 1;
    req_valid = '0; req_last = '0; req_data = '0;
    @(negedge CLK);
    Reset_n = 1'b1;

    // After reset requester 0 must win first again.
    auto_uart = 1;
    for (int r = NREQ - 1; r >= 0; r--) push_byte(r, 8'(8'hE0 + r), 1);
    model();
    drain(300, "drain_post_reset");
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
